// File: rtl/td4_pkg.sv
// td4_pkg: shared opcode constants, FSM state encoding and decoded
// control bundle for the TD4 sequencer.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A    = 4'b0000;
  localparam logic [3:0] OP_ADD_B    = 4'b0101;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JMP      = 4'b1111;
  localparam logic [3:0] OP_JNC      = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Source of the value written to A or B (non-ADD instructions).
  typedef enum logic [1:0] {
    SRC_IM = 2'd0,
    SRC_A  = 2'd1,
    SRC_B  = 2'd2,
    SRC_IN = 2'd3
  } src_e;

  typedef struct packed {
    logic a_we;    // write A
    logic b_we;    // write B
    src_e src;     // write source when not adding
    logic add_en;  // written register gets itself + im, carry from bit 4
    logic jmp;     // unconditional jump to im
    logic jnc;     // jump to im when carry is clear
    logic out_en;  // update out_port
    logic out_im;  // out_port source: 1 = im, 0 = B
  } dec_t;

endpackage

// File: rtl/td4_decoder.sv
// td4_decoder: purely combinational instruction decode.
//   rom_data : input  [7:0] instruction (op = [7:4], im = [3:0])
//   dec      : output dec_t register-write selects, jump, out and add enables
module td4_decoder
  import td4_pkg::*;
(
  input  logic [7:0] rom_data,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (rom_data[7:4])
      OP_ADD_A:    begin dec.a_we = 1'b1; dec.add_en = 1'b1; end
      OP_ADD_B:    begin dec.b_we = 1'b1; dec.add_en = 1'b1; end
      OP_MOV_A_IM: begin dec.a_we = 1'b1; dec.src = SRC_IM; end
      OP_MOV_B_IM: begin dec.b_we = 1'b1; dec.src = SRC_IM; end
      OP_MOV_A_B:  begin dec.a_we = 1'b1; dec.src = SRC_B;  end
      OP_MOV_B_A:  begin dec.b_we = 1'b1; dec.src = SRC_A;  end
      OP_IN_A:     begin dec.a_we = 1'b1; dec.src = SRC_IN; end
      OP_IN_B:     begin dec.b_we = 1'b1; dec.src = SRC_IN; end
      OP_OUT_B:    dec.out_en = 1'b1;
      OP_OUT_IM:   begin dec.out_en = 1'b1; dec.out_im = 1'b1; end
      OP_JMP:      dec.jmp = 1'b1;
      OP_JNC:      dec.jnc = 1'b1;
      default:     ;  // NOP
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4 4-bit CPU core (PC, A, B, carry, OUT) with an
// IDLE/RUN/HALT control FSM. Program ROM lives outside this block.
//   clk      : clock, all state changes on rising edge
//   rst_n    : asynchronous active-low reset
//   run      : level enable for execution
//   step_en  : one instruction retires per cycle with step_en high in RUN
//   rom_addr : program counter to the ROM
//   rom_data : combinational ROM instruction for rom_addr
//   in_port  : switches, sampled by IN A / IN B when they retire
//   out_port : registered LED output
//   carry    : carry flag
//   halted   : high in HALT (self-jump detected)
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned HALT_DETECT = 1,
  parameter logic [3:0]  PC_RESET    = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step_en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       carry_q, carry_d;
  logic [3:0] out_q, out_d;

  dec_t       dec;
  logic [3:0] im;
  logic [3:0] src_val;
  logic [3:0] addend;
  logic [4:0] sum;
  logic [3:0] wdata;
  logic       jump_taken;
  logic       self_jump;
  logic       retire;

  td4_decoder u_decoder (
    .rom_data (rom_data),
    .dec      (dec)
  );

  assign im = rom_data[3:0];

  always_comb begin
    src_val = im;
    case (dec.src)
      SRC_IM:  src_val = im;
      SRC_A:   src_val = a_q;
      SRC_B:   src_val = b_q;
      SRC_IN:  src_val = in_port;
      default: src_val = im;
    endcase

    addend     = dec.b_we ? b_q : a_q;
    sum        = {1'b0, addend} + {1'b0, im};
    wdata      = dec.add_en ? sum[3:0] : src_val;
    jump_taken = dec.jmp | (dec.jnc & ~carry_q);
    // A taken jump whose target is its own address can never progress.
    self_jump  = jump_taken && (im == pc_q);
    retire     = (state_q == ST_RUN) && run && step_en;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: if (run) state_d = ST_RUN;
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (retire && (HALT_DETECT != 0) && self_jump) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: if (!run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      if (dec.a_we)   a_d = wdata;
      if (dec.b_we)   b_d = wdata;
      if (dec.out_en) out_d = dec.out_im ? im : b_q;
      // Only ADDs leave a carry; every other instruction clears it.
      carry_d = dec.add_en & sum[4];
      pc_d    = jump_taken ? im : pc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      out_q   <= out_d;
    end
  end

  assign rom_addr = pc_q;
  assign out_port = out_q;
  assign carry    = carry_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_sequencer.sv
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       step_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       carry;
  logic       halted;

  logic [7:0] rom [16];

  int n_checks = 0;
  int n_errors = 0;
  bit model_chk = 1'b0;

  // Reference model: architectural state as plain integers.
  int m_pc, m_a, m_b, m_c, m_out;
  int m_mode;  // 0 idle, 1 running, 2 halted

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  td4_sequencer #(
    .HALT_DETECT (1),
    .PC_RESET    (4'b0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step_en  (step_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry),
    .halted   (halted)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_mode = 0;
  endtask

  // One clock edge of the instruction-set model, using the inputs
  // currently applied.
  task automatic model_step();
    int ins, op, im, s, npc, nc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (m_mode == 2) begin
      if (!run) m_mode = 0;
    end else if (!run) begin
      m_mode = 0;
    end else if (step_en) begin
      ins = int'(rom[m_pc]);
      op  = ins / 16;
      im  = ins % 16;
      npc = (m_pc + 1) % 16;
      nc  = 0;
      case (op)
        0:  begin s = m_a + im; m_a = s % 16; nc = (s > 15); end
        5:  begin s = m_b + im; m_b = s % 16; nc = (s > 15); end
        3:  m_a = im;
        7:  m_b = im;
        1:  m_a = m_b;
        4:  m_b = m_a;
        2:  m_a = int'(in_port);
        6:  m_b = int'(in_port);
        9:  m_out = m_b;
        11: m_out = im;
        15: npc = im;
        14: if (m_c == 0) npc = im;
        default: ;
      endcase
      if ((op == 15 || op == 14) && npc == m_pc) m_mode = 2;
      m_c  = nc;
      m_pc = npc;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (model_chk) begin
      chk("mdl_pc", rom_addr, m_pc);
      chk("mdl_out", out_port, m_out);
      chk("mdl_carry", carry, m_c);
      chk("mdl_halted", halted, (m_mode == 2));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; step_en = 1'b0;
    #1;
    chk("rst_pc", rom_addr, 4'h0);
    chk("rst_out", out_port, 4'h0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_halted", halted, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [7:0] pre, instr;
    logic [3:0] inp;
    logic       exp_c;
    logic [3:0] exp_pc, exp_out, exp_a, exp_b;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [3:0] p;

    clear_rom();
    in_port = 4'h0;

    // a, b, pre, instr, in -> carry, pc, out, A, B
    tbl[0]  = '{4'd7,  4'd0,  8'h80, 8'h09, 4'd0,  1'b1, 4'd4,  4'd0, 4'd0,  4'd0};
    tbl[1]  = '{4'd1,  4'd12, 8'h80, 8'h55, 4'd0,  1'b1, 4'd4,  4'd0, 4'd1,  4'd1};
    tbl[2]  = '{4'd3,  4'd0,  8'h80, 8'h04, 4'd0,  1'b0, 4'd4,  4'd0, 4'd7,  4'd0};
    tbl[3]  = '{4'd2,  4'd3,  8'h80, 8'h3A, 4'd0,  1'b0, 4'd4,  4'd0, 4'd10, 4'd3};
    tbl[4]  = '{4'd2,  4'd3,  8'h80, 8'h76, 4'd0,  1'b0, 4'd4,  4'd0, 4'd2,  4'd6};
    tbl[5]  = '{4'd2,  4'd9,  8'h80, 8'h10, 4'd0,  1'b0, 4'd4,  4'd0, 4'd9,  4'd9};
    tbl[6]  = '{4'd2,  4'd9,  8'h80, 8'h40, 4'd0,  1'b0, 4'd4,  4'd0, 4'd2,  4'd2};
    tbl[7]  = '{4'd1,  4'd1,  8'h80, 8'h20, 4'd13, 1'b0, 4'd4,  4'd0, 4'd13, 4'd1};
    tbl[8]  = '{4'd1,  4'd1,  8'h80, 8'h60, 4'd5,  1'b0, 4'd4,  4'd0, 4'd1,  4'd5};
    tbl[9]  = '{4'd0,  4'd6,  8'h80, 8'h90, 4'd0,  1'b0, 4'd4,  4'd6, 4'd0,  4'd6};
    tbl[10] = '{4'd0,  4'd0,  8'h80, 8'hB5, 4'd0,  1'b0, 4'd4,  4'd5, 4'd0,  4'd0};
    tbl[11] = '{4'd0,  4'd0,  8'h80, 8'hF9, 4'd0,  1'b0, 4'd9,  4'd0, 4'd0,  4'd0};
    tbl[12] = '{4'd0,  4'd0,  8'h80, 8'hEC, 4'd0,  1'b0, 4'd12, 4'd0, 4'd0,  4'd0};
    tbl[13] = '{4'd15, 4'd0,  8'h01, 8'h80, 4'd0,  1'b0, 4'd4,  4'd0, 4'd0,  4'd0};
    tbl[14] = '{4'd15, 4'd0,  8'h01, 8'hEC, 4'd0,  1'b0, 4'd4,  4'd0, 4'd0,  4'd0};
    tbl[15] = '{4'd8,  4'd15, 8'h80, 8'h5F, 4'd0,  1'b1, 4'd4,  4'd0, 4'd8,  4'd14};

    for (int v = 0; v < 16; v++) begin
      do_reset();
      clear_rom();
      rom[0] = {4'h3, tbl[v].a};
      rom[1] = {4'h7, tbl[v].b};
      rom[2] = tbl[v].pre;
      rom[3] = tbl[v].instr;
      in_port = tbl[v].inp;
      run = 1'b1; step_en = 1'b1;
      tick();
      chk($sformatf("v%0d_entry_pc", v), rom_addr, 4'd0);
      repeat (4) tick();
      chk($sformatf("v%0d_pc", v), rom_addr, tbl[v].exp_pc);
      chk($sformatf("v%0d_carry", v), carry, tbl[v].exp_c);
      chk($sformatf("v%0d_out", v), out_port, tbl[v].exp_out);
      chk($sformatf("v%0d_halted", v), halted, 1'b0);
      p = rom_addr;
      rom[p] = 8'h90;
      p = p + 4'd1; rom[p] = 8'h40;
      p = p + 4'd1; rom[p] = 8'h90;
      tick();
      chk($sformatf("v%0d_B", v), out_port, tbl[v].exp_b);
      tick(); tick();
      chk($sformatf("v%0d_A", v), out_port, tbl[v].exp_a);
    end

    // JNC taken/not taken from PC=2 with im=5.
    do_reset();
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE5; rom[3] = 8'hE5;
    run = 1'b1; step_en = 1'b1;
    tick(); tick(); tick();
    chk("jnc_pre_carry", carry, 1'b1);
    chk("jnc_pre_pc", rom_addr, 4'd2);
    tick();
    chk("jnc_c1_pc", rom_addr, 4'd3);
    chk("jnc_c1_carry", carry, 1'b0);
    tick();
    chk("jnc_c0_pc", rom_addr, 4'd5);

    // Self-jump at PC=15 halts; out_port persists; run low leaves HALT.
    do_reset();
    clear_rom();
    rom[0] = 8'hB8; rom[1] = 8'hFF; rom[15] = 8'hFF;
    run = 1'b1; step_en = 1'b1;
    tick(); tick(); tick();
    chk("halt_pre_pc", rom_addr, 4'd15);
    chk("halt_pre_halted", halted, 1'b0);
    tick();
    chk("halt_halted", halted, 1'b1);
    chk("halt_out", out_port, 4'b1000);
    repeat (3) tick();
    chk("halt_hold_pc", rom_addr, 4'd15);
    chk("halt_hold_halted", halted, 1'b1);
    chk("halt_hold_out", out_port, 4'b1000);
    run = 1'b0;
    tick();
    chk("halt_exit", halted, 1'b0);
    chk("halt_exit_out", out_port, 4'b1000);

    // NOP at PC=15 with carry set wraps to 0 and clears carry.
    do_reset();
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'hFE; rom[14] = 8'h01; rom[15] = 8'h80;
    run = 1'b1; step_en = 1'b1;
    repeat (4) tick();
    chk("wrap_pre_pc", rom_addr, 4'd15);
    chk("wrap_pre_carry", carry, 1'b1);
    tick();
    chk("wrap_pc", rom_addr, 4'd0);
    chk("wrap_carry", carry, 1'b0);

    // Asynchronous reset during a retiring OUT 0101.
    do_reset();
    clear_rom();
    rom[0] = 8'hBF; rom[1] = 8'hB5;
    run = 1'b1; step_en = 1'b1;
    tick(); tick();
    chk("arst_pre_out", out_port, 4'hF);
    chk("arst_pre_pc", rom_addr, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", out_port, 4'h0);
    chk("arst_pc", rom_addr, 4'd0);
    chk("arst_carry", carry, 1'b0);
    tick();
    chk("arst_edge_out", out_port, 4'h0);
    chk("arst_edge_pc", rom_addr, 4'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_entry_pc", rom_addr, 4'd0);
    chk("arst_entry_out", out_port, 4'h0);
    tick();
    chk("arst_first_pc", rom_addr, 4'd1);
    chk("arst_first_out", out_port, 4'hF);

    // step_en pulsed every 4th cycle against the model.
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    model_chk = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step_en = (c % 4 == 0);
      in_port = 4'($urandom);
      tick();
    end

    // Fully random control against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) begin
        model_chk = 1'b0;
        do_reset();
        model_chk = 1'b1;
      end
      run     = ($urandom_range(0, 7) != 0);
      step_en = ($urandom_range(0, 2) != 0);
      in_port = 4'($urandom);
      if ($urandom_range(0, 9) == 0) rom[$urandom_range(0, 15)] = 8'($urandom);
      tick();
    end
    model_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/td4_sequencer.md
TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 SHALL: parameter HALT_DETECT, default 1, meaning 1 enables self-jump halt detection and 0 disables it.
REQ-002 SHALL: parameter PC_RESET, default 4'b0000, meaning the program counter value loaded at reset.
REQ-003 SHALL: port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL: port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 SHALL: port run, input, 1 bit, level-sensitive enable for continuous execution.
REQ-006 SHALL: port step_en, input, 1 bit, execution tick; one instruction retires per cycle in which it is high and the core is executing.
REQ-007 SHALL: port rom_addr, output, 4 bits, program counter driven to the program ROM.
REQ-008 SHALL: port rom_data, input, 8 bits, instruction from the combinational ROM, valid in the same cycle.
REQ-009 SHALL: port in_port, input, 4 bits, external switches, sampled by the IN instructions.
REQ-010 SHALL: port out_port, output, 4 bits, registered LED output.
REQ-011 SHALL: port carry, output, 1 bit, current carry flag.
REQ-012 SHALL: port halted, output, 1 bit, high while in the HALT state.

Function
REQ-013 SHALL: the instruction field is op = rom_data[7:4] and im = rom_data[3:0].
REQ-014 SHALL: decode the opcodes as follows.
- 0000: A = A + im
- 0101: B = B + im
- 0011: A = im
- 0111: B = im
- 0001: A = B
- 0100: B = A
- 0010: A = in_port
- 0110: B = in_port
- 1001: OUT B
- 1011: OUT im
- 1111: JMP im
- 1110: JNC im
- all other opcodes: NOP
REQ-015 SHALL: additions are 4-bit wrap-around, and the carry is set to the bit-4 carry-out.
REQ-016 SHALL: every non-ADD instruction, including NOP and jumps, clears the carry on retirement.
REQ-017 SHALL: JNC loads im into the PC when carry==0 before the instruction, otherwise PC+1.
REQ-018 SHALL: PC increments modulo 16, so 4'b1111 wraps to 4'b0000.
REQ-019 SHALL: latency is 1 cycle; A, B, carry, out_port and PC all update on the edge where the instruction retires.
REQ-020 SHALL: the state machine has three states, IDLE, RUN and HALT.
- IDLE→RUN when run==1.
- RUN→IDLE when run==0, with no retirement in that cycle.
- RUN→HALT when HALT_DETECT==1 and the retiring instruction is JMP with im==rom_addr (also JNC with im==rom_addr and carry==0).
- HALT→IDLE when run==0.
REQ-021 SHALL: instructions retire only when state==RUN, run==1 and step_en==1; otherwise all architectural state holds.
REQ-022 SHALL: in HALT, rom_addr holds and no retirement occurs; halted==1.
REQ-023 SHALL: when run and step_en rise simultaneously from IDLE, the first retirement occurs no earlier than the cycle after entering RUN.
REQ-024 SHALL: the IN instructions sample in_port in the retiring cycle only; no synchronizer is provided, and in_port is assumed registered upstream.

Reset
REQ-025 SHALL: while rst_n==0, hold state=IDLE, PC=PC_RESET, A=0, B=0, carry=0, out_port=4'b0000 and halted=0.
REQ-026 SHALL: reset asserted mid-instruction discards that instruction, and no partial update is visible.
REQ-027 SHALL: after rst_n deasserts, the first retirement requires a RUN entry per REQ-023.

Structure
REQ-028 SHALL: opcode constants and the state encoding live in the shared package td4_pkg.
REQ-029 SHALL: decode is a combinational sub-module, td4_decoder (rom_data → register-write selects, jump, out-enable, add-enable).
REQ-030 SHALL: the rom module instantiates unchanged outside this block; this block contains no program storage.

Verification
REQ-031 SHALL: program 0011_0111, 0000_1001, 1001_0000 with B=0 runs to retirement 2 → A=0; carry=1 after the ADD (7+9=16).
REQ-032 SHALL: JNC with carry=1 at PC=2, im=5 → PC=3; JNC with carry=0 → PC=5.
REQ-033 SHALL: the ramen-timer program at PC=15, 1111_1111, gives halted=1 within 1 cycle, and out_port=4'b1000 persists.
REQ-034 SHALL: step_en toggled every 4th cycle with run=1 → exactly one retirement per step_en pulse, and the PC sequence matches a golden model.
REQ-035 SHALL: rst_n asserted in the same cycle as a retiring OUT 0101 → out_port=0000, PC=PC_RESET, and state=IDLE asynchronously.
REQ-036 SHALL: PC=15 with NOP retiring → PC=0 and carry=0.
